// File: rtl/vw_fifo_if.sv
// Producer/consumer handshake bundle for vw_fifo: variable-count write and read
// ports, FWFT read lanes, occupancy and status flags.
interface vw_fifo_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int PAR_WRITE  = 4,
   parameter int PAR_READ   = 4
) ();
   localparam int WCW = $clog2(PAR_WRITE + 1);
   localparam int RCW = $clog2(PAR_READ + 1);

   logic                           clear;
   logic                           wen;
   logic [WCW-1:0]                 wcnt;
   logic [PAR_WRITE*DATA_WIDTH-1:0] din;
   logic                           ren;
   logic [RCW-1:0]                 rcnt;
   logic [PAR_READ*DATA_WIDTH-1:0] dout;
   logic [ADDR_WIDTH:0]            count;
   logic                           full;
   logic                           empty;
   logic                           almost_full;
   logic                           almost_empty;
   logic                           ready;
   logic                           valid;
   logic                           ovf;
   logic                           udf;

   // Upstream/downstream stage side: issues requests, observes data and status
   modport master (
      output clear, wen, wcnt, din, ren, rcnt,
      input  dout, count, full, empty, almost_full, almost_empty,
      input  ready, valid, ovf, udf
   );

   // FIFO side
   modport slave (
      input  clear, wen, wcnt, din, ren, rcnt,
      output dout, count, full, empty, almost_full, almost_empty,
      output ready, valid, ovf, udf
   );
endinterface

// File: rtl/vw_fifo.sv
// Variable-width FWFT FIFO: up to PAR_WRITE words pushed and PAR_READ words popped
// per cycle, counts chosen at run time, with reject pulses for refused operations.
module vw_fifo #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int PAR_WRITE  = 4,
   parameter int PAR_READ   = 4,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input logic      clk,
   input logic      rstn,
   vw_fifo_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr_q;
   logic [ADDR_WIDTH-1:0] wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q;
   logic [ADDR_WIDTH-1:0] rptr_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  ovf_q;
   logic                  ovf_d;
   logic                  udf_q;
   logic                  udf_d;

   logic [CNT_W-1:0]      wcnt_ext_s;
   logic [CNT_W-1:0]      rcnt_ext_s;
   logic [CNT_W-1:0]      space_s;
   logic                  ready_s;
   logic                  valid_s;
   logic                  wacc_s;
   logic                  racc_s;
   logic [ADDR_WIDTH-1:0] waddr_s [PAR_WRITE];
   logic                  lane_we_s [PAR_WRITE];
   logic [PAR_READ*DATA_WIDTH-1:0] dout_s;

   // Acceptance: decided from the current count only, so a same-cycle pop never frees space for a push
   always_comb begin
      wcnt_ext_s = CNT_W'(bus.wcnt);
      rcnt_ext_s = CNT_W'(bus.rcnt);
      space_s    = CNT_W'(DEPTH) - count_q;
      ready_s    = (wcnt_ext_s != {CNT_W{1'b0}}) &&
                   (wcnt_ext_s <= CNT_W'(PAR_WRITE)) &&
                   (space_s >= wcnt_ext_s);
      valid_s    = (rcnt_ext_s != {CNT_W{1'b0}}) &&
                   (rcnt_ext_s <= CNT_W'(PAR_READ)) &&
                   (count_q >= rcnt_ext_s);
      wacc_s     = rstn && !bus.clear && bus.wen && ready_s;
      racc_s     = rstn && !bus.clear && bus.ren && valid_s;
   end

   // Per-lane write addresses and enables; lane i lands at wptr+i modulo DEPTH
   always_comb begin
      for (int i = 0; i < PAR_WRITE; i++) begin
         waddr_s[i]   = wptr_q + ADDR_WIDTH'(i);
         lane_we_s[i] = wacc_s && (CNT_W'(i) < wcnt_ext_s);
      end
   end

   // Storage next state: each slot takes the lane aimed at it, if any (lane addresses never collide)
   always_comb begin
      for (int a = 0; a < DEPTH; a++) begin
         mem_d[a] = mem_q[a];
         for (int i = 0; i < PAR_WRITE; i++) begin
            mem_d[a] = (lane_we_s[i] && (waddr_s[i] == ADDR_WIDTH'(a)))
                       ? bus.din[i*DATA_WIDTH +: DATA_WIDTH] : mem_d[a];
         end
      end
   end

   // Pointer, occupancy and reject-pulse next state; clear acts like reset and suppresses pulses
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (bus.clear) begin
         wptr_d  = {ADDR_WIDTH{1'b0}};
         rptr_d  = {ADDR_WIDTH{1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         wptr_d  = wacc_s ? (wptr_q + ADDR_WIDTH'(wcnt_ext_s)) : wptr_q;
         rptr_d  = racc_s ? (rptr_q + ADDR_WIDTH'(rcnt_ext_s)) : rptr_q;
         count_d = count_q
                   + (wacc_s ? wcnt_ext_s : {CNT_W{1'b0}})
                   - (racc_s ? rcnt_ext_s : {CNT_W{1'b0}});
         ovf_d   = bus.wen && !ready_s;
         udf_d   = bus.ren && !valid_s;
      end
   end

   // Control state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q  <= {ADDR_WIDTH{1'b0}};
         rptr_q  <= {ADDR_WIDTH{1'b0}};
         count_q <= {CNT_W{1'b0}};
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      for (int a = 0; a < DEPTH; a++) begin
         mem_q[a] <= mem_d[a];
      end
   end

   // First-word-fall-through lanes; slots beyond the occupancy read as zero
   always_comb begin
      dout_s = {(PAR_READ*DATA_WIDTH){1'b0}};
      for (int j = 0; j < PAR_READ; j++) begin
         dout_s[j*DATA_WIDTH +: DATA_WIDTH] =
            (CNT_W'(j) < count_q) ? mem_q[rptr_q + ADDR_WIDTH'(j)]
                                  : {DATA_WIDTH{1'b0}};
      end
   end

   assign bus.dout         = dout_s;
   assign bus.count        = count_q;
   assign bus.full         = (count_q == CNT_W'(DEPTH));
   assign bus.empty        = (count_q == {CNT_W{1'b0}});
   assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign bus.ready        = ready_s;
   assign bus.valid        = valid_s;
   assign bus.ovf          = ovf_q;
   assign bus.udf          = udf_q;
endmodule

// File: tb/tb_vw_fifo.sv
// Directed bench for vw_fifo: reset/clear, variable reads and writes, over/underflow,
// simultaneous access across pointer wrap, and almost-flag thresholds.
module tb_vw_fifo;
   logic clk;
   logic rstn;
   int   tests_run;
   int   tests_failed;

   vw_fifo_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .PAR_WRITE(4), .PAR_READ(4)) bus ();

   vw_fifo #(
      .ADDR_WIDTH(3), .DATA_WIDTH(8), .PAR_WRITE(4), .PAR_READ(4),
      .AF_LEVEL(6), .AE_LEVEL(2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.clear = 1'b0;
      bus.wen   = 1'b0;
      bus.ren   = 1'b0;
      bus.wcnt  = 3'd0;
      bus.rcnt  = 3'd0;
   endtask

   task automatic wr(input int n, input logic [31:0] d);
      bus.wen  = 1'b1;
      bus.wcnt = 3'(n);
      bus.din  = d;
      tick();
      bus.wen  = 1'b0;
   endtask

   task automatic rd(input int n);
      bus.ren  = 1'b1;
      bus.rcnt = 3'(n);
      tick();
      bus.ren  = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      idle();
      bus.din = 32'h0;
      rstn    = 1'b0;
      tick();
      tick();

      // 1: reset and clear
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_empty", 32'(bus.empty), 32'd1);
      check_eq("rst_full", 32'(bus.full), 32'd0);
      check_eq("rst_ae", 32'(bus.almost_empty), 32'd1);
      check_eq("rst_af", 32'(bus.almost_full), 32'd0);
      check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
      check_eq("rst_udf", 32'(bus.udf), 32'd0);
      check_eq("rst_dout", bus.dout, 32'h0);
      bus.rcnt = 3'd1;
      #1;
      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      rstn = 1'b1;
      wr(3, 32'h00030201);
      check_eq("pre_clr_count", 32'(bus.count), 32'd3);
      bus.clear = 1'b1;
      bus.wen   = 1'b1;
      bus.wcnt  = 3'd2;
      bus.din   = 32'h0000BBAA;
      tick();
      idle();
      check_eq("clr_count", 32'(bus.count), 32'd0);
      check_eq("clr_empty", 32'(bus.empty), 32'd1);
      check_eq("clr_ovf", 32'(bus.ovf), 32'd0);
      check_eq("clr_dout", bus.dout, 32'h0);

      // 2: variable write then read
      bus.wcnt = 3'd3;
      #1;
      check_eq("w3_ready", 32'(bus.ready), 32'd1);
      wr(3, 32'hAA030201);
      check_eq("w3_count", 32'(bus.count), 32'd3);
      check_eq("w3_dout", bus.dout, 32'h00030201);
      check_eq("w3_ae", 32'(bus.almost_empty), 32'd0);
      bus.rcnt = 3'd2;
      #1;
      check_eq("r2_valid", 32'(bus.valid), 32'd1);
      rd(2);
      check_eq("r2_count", 32'(bus.count), 32'd1);
      check_eq("r2_dout", bus.dout, 32'h00000003);
      check_eq("r2_ae", 32'(bus.almost_empty), 32'd1);

      // 3: overflow on a full FIFO
      do_clear();
      wr(4, 32'h04030201);
      wr(4, 32'h08070605);
      check_eq("full_count", 32'(bus.count), 32'd8);
      check_eq("full_flag", 32'(bus.full), 32'd1);
      check_eq("full_af", 32'(bus.almost_full), 32'd1);
      check_eq("full_dout", bus.dout, 32'h04030201);
      bus.wcnt = 3'd1;
      #1;
      check_eq("full_ready", 32'(bus.ready), 32'd0);
      wr(1, 32'h00000099);
      check_eq("ovf_pulse", 32'(bus.ovf), 32'd1);
      check_eq("ovf_count", 32'(bus.count), 32'd8);
      check_eq("ovf_dout", bus.dout, 32'h04030201);
      tick();
      check_eq("ovf_drop", 32'(bus.ovf), 32'd0);

      // 4: underflow and illegal counts
      rd(4);
      rd(3);
      check_eq("c1_count", 32'(bus.count), 32'd1);
      check_eq("c1_dout", bus.dout, 32'h00000008);
      bus.rcnt = 3'd2;
      #1;
      check_eq("udf_valid", 32'(bus.valid), 32'd0);
      rd(2);
      check_eq("udf_pulse", 32'(bus.udf), 32'd1);
      check_eq("udf_count", 32'(bus.count), 32'd1);
      check_eq("udf_dout", bus.dout, 32'h00000008);
      tick();
      check_eq("udf_drop", 32'(bus.udf), 32'd0);
      bus.wcnt = 3'd0;
      #1;
      check_eq("w0_ready", 32'(bus.ready), 32'd0);
      wr(0, 32'h000000EE);
      check_eq("w0_ovf", 32'(bus.ovf), 32'd1);
      check_eq("w0_count", 32'(bus.count), 32'd1);
      bus.wcnt = 3'd5;
      #1;
      check_eq("w5_ready", 32'(bus.ready), 32'd0);
      wr(5, 32'h000000EE);
      check_eq("w5_ovf", 32'(bus.ovf), 32'd1);
      check_eq("w5_count", 32'(bus.count), 32'd1);
      check_eq("w5_dout", bus.dout, 32'h00000008);

      // 5: simultaneous access across wrap, starting with rptr=5
      do_clear();
      wr(4, 32'h0);
      wr(1, 32'h0);
      rd(4);
      rd(1);
      check_eq("wrap_empty", 32'(bus.empty), 32'd1);
      wr(4, 32'h14131211);
      wr(3, 32'h00171615);
      check_eq("c7_count", 32'(bus.count), 32'd7);
      check_eq("c7_dout", bus.dout, 32'h14131211);
      bus.wen  = 1'b1;
      bus.wcnt = 3'd1;
      bus.din  = 32'h00000018;
      bus.ren  = 1'b1;
      bus.rcnt = 3'd4;
      #1;
      check_eq("sim_ready", 32'(bus.ready), 32'd1);
      check_eq("sim_valid", 32'(bus.valid), 32'd1);
      tick();
      idle();
      check_eq("sim_count", 32'(bus.count), 32'd4);
      check_eq("sim_dout", bus.dout, 32'h18171615);
      check_eq("sim_ovf", 32'(bus.ovf), 32'd0);
      check_eq("sim_udf", 32'(bus.udf), 32'd0);
      wr(4, 32'h1C1B1A19);
      check_eq("c8_full", 32'(bus.full), 32'd1);
      bus.wen  = 1'b1;
      bus.wcnt = 3'd1;
      bus.din  = 32'h00000077;
      bus.ren  = 1'b1;
      bus.rcnt = 3'd4;
      #1;
      check_eq("simf_ready", 32'(bus.ready), 32'd0);
      check_eq("simf_valid", 32'(bus.valid), 32'd1);
      tick();
      idle();
      check_eq("simf_ovf", 32'(bus.ovf), 32'd1);
      check_eq("simf_udf", 32'(bus.udf), 32'd0);
      check_eq("simf_count", 32'(bus.count), 32'd4);
      check_eq("simf_dout", bus.dout, 32'h1C1B1A19);

      // 6: almost-flag thresholds stepping up then down
      do_clear();
      for (int k = 0; k <= 8; k++) begin
         check_eq($sformatf("up_count_%0d", k), 32'(bus.count), 32'(k));
         check_eq($sformatf("up_ae_%0d", k), 32'(bus.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
         check_eq($sformatf("up_af_%0d", k), 32'(bus.almost_full), (k >= 6) ? 32'd1 : 32'd0);
         check_eq($sformatf("up_empty_%0d", k), 32'(bus.empty), (k == 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("up_full_%0d", k), 32'(bus.full), (k == 8) ? 32'd1 : 32'd0);
         if (k < 8) wr(1, 32'(k + 8'h30));
      end
      for (int k = 8; k >= 0; k--) begin
         check_eq($sformatf("dn_count_%0d", k), 32'(bus.count), 32'(k));
         check_eq($sformatf("dn_ae_%0d", k), 32'(bus.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
         check_eq($sformatf("dn_af_%0d", k), 32'(bus.almost_full), (k >= 6) ? 32'd1 : 32'd0);
         if (k > 0) rd(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
